// File: rtl/syndrome_decoder.sv
// Syndrome decoder for a 12-bit codeword (7 data bits r0..r6, 5 parity bits r7..r11).
// Two-stage valid/ready pipeline: stage 1 captures the word and its syndrome,
// stage 2 holds the decoded data, the correction/uncorrectable flags and the raw
// syndrome. Two saturating counters track corrected and uncorrectable words as
// they leave the block.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input handshake, in_code = received codeword
//   out_valid/out_ready output handshake
//   out_data            decoded data bits
//   out_corrected       a single bit was corrected
//   out_uncorr          error detected but not correctable
//   out_syndrome        raw syndrome s4..s0
//   clr_cnt             synchronous clear of both counters
//   cnt_corr/cnt_uncorr saturating statistics counters
module syndrome_decoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_data,
    output logic             out_corrected,
    output logic             out_uncorr,
    output logic [4:0]       out_syndrome,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_uncorr
);

    localparam int unsigned CODE_W = 12;
    localparam int unsigned DATA_W = 7;
    localparam int unsigned SYN_W  = 5;

    logic              adv;
    logic              in_hs;
    logic              out_hs;
    logic [SYN_W-1:0]  syn_c;

    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic [SYN_W-1:0]  s1_syn;

    logic [DATA_W-1:0] dec_data_c;
    logic              dec_corr_c;
    logic              dec_uncorr_c;

    // Both stages move together whenever the output slot is free or draining.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign in_hs    = in_valid && adv;
    assign out_hs   = out_valid && out_ready;

    // Syndrome of the incoming word.
    always_comb begin
        syn_c    = '0;
        syn_c[0] = in_code[7]  ^ in_code[0] ^ in_code[1] ^ in_code[5] ^ in_code[6];
        syn_c[1] = in_code[8]  ^ in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[5];
        syn_c[2] = in_code[9]  ^ in_code[0] ^ in_code[1] ^ in_code[3] ^ in_code[5] ^ in_code[6];
        syn_c[3] = in_code[10] ^ in_code[0] ^ in_code[1] ^ in_code[3] ^ in_code[5] ^ in_code[6];
        syn_c[4] = in_code[11] ^ in_code[1] ^ in_code[3] ^ in_code[5] ^ in_code[6];
    end

    // Classify the stage-1 syndrome. Parity-bit hits only raise the flag; data
    // is untouched. Ambiguous patterns (00010, 11101) fall into the default.
    always_comb begin
        dec_data_c   = s1_code[DATA_W-1:0];
        dec_corr_c   = 1'b0;
        dec_uncorr_c = 1'b0;
        case (s1_syn)
            5'b00000: ;
            5'b01111: begin
                dec_data_c[0] = ~s1_code[0];
                dec_corr_c    = 1'b1;
            end
            5'b11100: begin
                dec_data_c[3] = ~s1_code[3];
                dec_corr_c    = 1'b1;
            end
            5'b11111: begin
                dec_data_c[5] = ~s1_code[5];
                dec_corr_c    = 1'b1;
            end
            5'b00001, 5'b00100, 5'b01000, 5'b10000: dec_corr_c = 1'b1;
            default: dec_uncorr_c = 1'b1;
        endcase
    end

    // Stage 1: captured codeword and syndrome.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
        end else if (adv) begin
            s1_valid <= in_hs;
            s1_code  <= in_code;
            s1_syn   <= syn_c;
        end
    end

    // Stage 2: decoded output word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_corrected <= 1'b0;
            out_uncorr    <= 1'b0;
            out_syndrome  <= '0;
        end else if (adv) begin
            out_valid     <= s1_valid;
            out_data      <= dec_data_c;
            out_corrected <= dec_corr_c;
            out_uncorr    <= dec_uncorr_c;
            out_syndrome  <= s1_syn;
        end
    end

    // Saturating statistics counters; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (clr_cnt) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else begin
            if (out_hs && out_corrected && (cnt_corr != '1)) begin
                cnt_corr <= cnt_corr + CNT_W'(1);
            end
            if (out_hs && out_uncorr && (cnt_uncorr != '1)) begin
                cnt_uncorr <= cnt_uncorr + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_syndrome_decoder.sv
// Directed bench for syndrome_decoder: one default-width instance for the
// datapath/handshake scenarios and one CNT_W=4 instance for saturation.
module tb_syndrome_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_code;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_data;
    logic        out_corrected;
    logic        out_uncorr;
    logic [4:0]  out_syndrome;
    logic        clr_cnt;
    logic [15:0] cnt_corr;
    logic [15:0] cnt_uncorr;

    logic        i4_valid;
    logic        r4_ready;
    logic [11:0] i4_code;
    logic        o4_valid;
    logic        o4_ready;
    logic [6:0]  o4_data;
    logic        o4_corr;
    logic        o4_uncorr;
    logic [4:0]  o4_syn;
    logic        clr4;
    logic [3:0]  cnt4_corr;
    logic [3:0]  cnt4_uncorr;

    int checks   = 0;
    int failures = 0;
    int exp_cc   = 0;
    int exp_cu   = 0;

    always #5 clk = ~clk;

    syndrome_decoder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_corrected(out_corrected), .out_uncorr(out_uncorr),
        .out_syndrome(out_syndrome), .clr_cnt(clr_cnt),
        .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
    );

    syndrome_decoder #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i4_valid), .in_ready(r4_ready), .in_code(i4_code),
        .out_valid(o4_valid), .out_ready(o4_ready), .out_data(o4_data),
        .out_corrected(o4_corr), .out_uncorr(o4_uncorr),
        .out_syndrome(o4_syn), .clr_cnt(clr4),
        .cnt_corr(cnt4_corr), .cnt_uncorr(cnt4_uncorr)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present one word for a single cycle, then let it reach stage 2.
    task automatic send_word(input logic [11:0] code);
        in_valid = 1'b1;
        in_code  = code;
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1; in_code = 12'h780; out_ready = 1'b1; clr_cnt = 1'b0;
        i4_valid = 1'b0; i4_code = 12'h000; o4_ready = 1'b1; clr4 = 1'b0;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 7'h00 || out_corrected !== 1'b0 || out_uncorr !== 1'b0 || out_syndrome !== 5'h00) begin
            failures++; $display("FAIL reset_outputs got data=%h c=%b u=%b syn=%h exp all 0", out_data, out_corrected, out_uncorr, out_syndrome); end
        checks++; if (cnt_corr !== 16'h0 || cnt_uncorr !== 16'h0) begin
            failures++; $display("FAIL reset_counters got %h/%h exp 0/0", cnt_corr, cnt_uncorr); end
        checks++; if (cnt4_corr !== 4'h0 || o4_valid !== 1'b0) begin
            failures++; $display("FAIL reset_dut4 got cnt=%h v=%b exp 0/0", cnt4_corr, o4_valid); end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_clean;
        in_valid = 1'b1; in_code = 12'h781; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clean_early_valid got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 7'h01 || out_corrected !== 1'b0 || out_uncorr !== 1'b0 || out_syndrome !== 5'h00) begin
            failures++; $display("FAIL clean_word got v=%b data=%h c=%b u=%b syn=%h exp v=1 data=01 c=0 u=0 syn=00",
                out_valid, out_data, out_corrected, out_uncorr, out_syndrome); end
        step();
        checks++; if (out_valid !== 1'b0 || cnt_corr !== 16'(exp_cc) || cnt_uncorr !== 16'(exp_cu)) begin
            failures++; $display("FAIL clean_after got v=%b cc=%0d cu=%0d exp v=0 cc=%0d cu=%0d", out_valid, cnt_corr, cnt_uncorr, exp_cc, exp_cu); end
    endtask

    task automatic test_correct;
        send_word(12'h780);
        checks++; if (out_valid !== 1'b1 || out_data !== 7'h01 || out_corrected !== 1'b1 || out_uncorr !== 1'b0 || out_syndrome !== 5'h0F) begin
            failures++; $display("FAIL correct_r0 got v=%b data=%h c=%b u=%b syn=%h exp v=1 data=01 c=1 u=0 syn=0f",
                out_valid, out_data, out_corrected, out_uncorr, out_syndrome); end
        step();
        exp_cc = 1;
        checks++; if (cnt_corr !== 16'd1 || cnt_uncorr !== 16'd0) begin
            failures++; $display("FAIL correct_count got cc=%0d cu=%0d exp 1/0", cnt_corr, cnt_uncorr); end
    endtask

    task automatic test_uncorr;
        send_word(12'h004);
        checks++; if (out_valid !== 1'b1 || out_data !== 7'h04 || out_corrected !== 1'b0 || out_uncorr !== 1'b1 || out_syndrome !== 5'h02) begin
            failures++; $display("FAIL uncorr_r2 got v=%b data=%h c=%b u=%b syn=%h exp v=1 data=04 c=0 u=1 syn=02",
                out_valid, out_data, out_corrected, out_uncorr, out_syndrome); end
        step();
        exp_cu = 1;
        checks++; if (cnt_corr !== 16'd1 || cnt_uncorr !== 16'd1) begin
            failures++; $display("FAIL uncorr_count got cc=%0d cu=%0d exp 1/1", cnt_corr, cnt_uncorr); end
    endtask

    typedef struct {
        logic [11:0] code;
        logic [6:0]  data;
        logic        corr;
        logic        unc;
        logic [4:0]  syn;
    } vec_t;

    task automatic test_patterns;
        vec_t tbl[10];
        tbl[0] = '{12'hE00, 7'h08, 1'b1, 1'b0, 5'b11100}; // r3 flipped
        tbl[1] = '{12'h020, 7'h00, 1'b1, 1'b0, 5'b11111}; // r5 flipped
        tbl[2] = '{12'h800, 7'h00, 1'b1, 1'b0, 5'b10000}; // r11 flipped
        tbl[3] = '{12'h001, 7'h00, 1'b1, 1'b0, 5'b01111}; // r0 flipped
        tbl[4] = '{12'h002, 7'h02, 1'b0, 1'b1, 5'b11101}; // r1/r6 ambiguous
        tbl[5] = '{12'h080, 7'h00, 1'b1, 1'b0, 5'b00001}; // r7 flipped
        tbl[6] = '{12'h200, 7'h00, 1'b1, 1'b0, 5'b00100}; // r9 flipped
        tbl[7] = '{12'h400, 7'h00, 1'b1, 1'b0, 5'b01000}; // r10 flipped
        tbl[8] = '{12'h100, 7'h00, 1'b0, 1'b1, 5'b00010}; // r8 ambiguous
        tbl[9] = '{12'h003, 7'h03, 1'b0, 1'b1, 5'b10010}; // double error
        for (int i = 0; i < 10; i++) begin
            send_word(tbl[i].code);
            checks++;
            if (out_valid !== 1'b1 || out_data !== tbl[i].data || out_corrected !== tbl[i].corr ||
                out_uncorr !== tbl[i].unc || out_syndrome !== tbl[i].syn) begin
                failures++;
                $display("FAIL pattern_%03h got v=%b data=%h c=%b u=%b syn=%b exp v=1 data=%h c=%b u=%b syn=%b",
                    tbl[i].code, out_valid, out_data, out_corrected, out_uncorr, out_syndrome,
                    tbl[i].data, tbl[i].corr, tbl[i].unc, tbl[i].syn);
            end
            if (tbl[i].corr) exp_cc++;
            if (tbl[i].unc)  exp_cu++;
            step();
        end
        checks++; if (cnt_corr !== 16'(exp_cc) || cnt_uncorr !== 16'(exp_cu)) begin
            failures++; $display("FAIL pattern_counts got cc=%0d cu=%0d exp %0d/%0d", cnt_corr, cnt_uncorr, exp_cc, exp_cu); end
    endtask

    task automatic test_back_to_back;
        logic [11:0] words[3];
        logic [6:0]  exp_data[3];
        int idx;
        int got;
        words[0] = 12'h781; exp_data[0] = 7'h01;
        words[1] = 12'h104; exp_data[1] = 7'h04;
        words[2] = 12'hE08; exp_data[2] = 7'h08;
        idx = 0;
        got = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = (idx < 3);
            in_code  = words[(idx > 2) ? 2 : idx];
            #1;
            if (cyc >= 2) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 7'h01 || out_syndrome !== 5'h00) begin
                    failures++;
                    $display("FAIL stall_cycle%0d got rdy=%b v=%b data=%h syn=%h exp rdy=0 v=1 data=01 syn=00",
                        cyc, in_ready, out_valid, out_data, out_syndrome);
                end
            end
            if (in_valid && in_ready) idx++;
            step();
        end
        checks++; if (idx != 2) begin failures++; $display("FAIL stall_accepted got=%0d exp=2", idx); end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            in_valid = (idx < 3);
            in_code  = words[(idx > 2) ? 2 : idx];
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (got >= 3) begin
                    failures++; $display("FAIL drain_duplicate got data=%h exp no word", out_data);
                end else if (out_data !== exp_data[got]) begin
                    failures++; $display("FAIL drain_word%0d got data=%h exp=%h", got, out_data, exp_data[got]);
                end
                got++;
            end
            if (in_valid && in_ready) idx++;
            step();
        end
        in_valid = 1'b0;
        checks++; if (got != 3) begin failures++; $display("FAIL drain_count got=%0d exp=3", got); end
    endtask

    task automatic test_clear;
        send_word(12'h780);
        clr_cnt = 1'b1;
        checks++; if (out_valid !== 1'b1 || out_corrected !== 1'b1 || cnt_corr !== 16'(exp_cc)) begin
            failures++; $display("FAIL clear_setup got v=%b c=%b cc=%0d exp v=1 c=1 cc=%0d", out_valid, out_corrected, cnt_corr, exp_cc); end
        step();
        clr_cnt = 1'b0;
        exp_cc = 0; exp_cu = 0;
        checks++; if (cnt_corr !== 16'd0 || cnt_uncorr !== 16'd0) begin
            failures++; $display("FAIL clear_wins got cc=%0d cu=%0d exp 0/0", cnt_corr, cnt_uncorr); end
    endtask

    task automatic test_saturate;
        i4_valid = 1'b1; i4_code = 12'h780; o4_ready = 1'b1;
        repeat (17) step();
        i4_valid = 1'b0;
        repeat (3) step();
        checks++; if (cnt4_corr !== 4'hF || cnt4_uncorr !== 4'h0) begin
            failures++; $display("FAIL saturate got cc=%h cu=%h exp f/0", cnt4_corr, cnt4_uncorr); end
        i4_valid = 1'b1;
        step();
        i4_valid = 1'b0;
        step();
        clr4 = 1'b1;
        checks++; if (o4_valid !== 1'b1 || o4_corr !== 1'b1 || o4_data !== 7'h01) begin
            failures++; $display("FAIL sat_clear_setup got v=%b c=%b data=%h exp 1/1/01", o4_valid, o4_corr, o4_data); end
        step();
        clr4 = 1'b0;
        checks++; if (cnt4_corr !== 4'h0) begin failures++; $display("FAIL sat_clear got cc=%h exp 0", cnt4_corr); end
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b1;
        in_valid = 1'b1; in_code = 12'h780; step();
        in_code = 12'h780; step();
        in_code = 12'h004; step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || cnt_corr !== 16'd1) begin
            failures++; $display("FAIL midreset_setup got v=%b cc=%0d exp v=1 cc=1", out_valid, cnt_corr); end
        rst_n = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || out_data !== 7'h00 || out_syndrome !== 5'h00 || cnt_corr !== 16'd0 || cnt_uncorr !== 16'd0) begin
            failures++; $display("FAIL midreset_state got v=%b data=%h syn=%h cc=%0d cu=%0d exp all 0",
                out_valid, out_data, out_syndrome, cnt_corr, cnt_uncorr); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got=%b exp=1", in_ready); end
        for (int cyc = 0; cyc < 6; cyc++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin
                failures++; $display("FAIL midreset_stale cycle%0d got v=%b data=%h exp v=0", cyc, out_valid, out_data); end
        end
        checks++; if (cnt_corr !== 16'd0 || cnt_uncorr !== 16'd0) begin
            failures++; $display("FAIL midreset_counts got cc=%0d cu=%0d exp 0/0", cnt_corr, cnt_uncorr); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_correct();
        test_uncorr();
        test_patterns();
        test_back_to_back();
        test_clear();
        test_saturate();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
